inst_ram_loader: RTL and testbench
==================================

# inst_ram_loader

Writable instruction memory for the single-cycle CPU: a 256×32 word store whose read side matches the instruction-ROM contract (`Addr` in, `INST` out, word index `Addr[9:2]`). Its write side is a byte-stream loader: a host sends a start command, then streams bytes over a valid/ready handshake. The block packs every four bytes into an instruction word and writes it into the store. `cpu_stall` holds the CPU while a load is in progress.

## Interface
Parameters:
- DEPTH_LOG2, 8 — address bits of the word store (256 words).

Ports:
- clk  input  1  — single clock. All state updates on the rising edge.
- rst_n  input  1  — reset. Synchronous, active-low.
- Addr  input  32  — CPU instruction address. Word index is `Addr[9:2]`.
- INST  output  32  — combinational read data, `store[Addr[9:2]]`.
- load_start  input  1  — one-cycle command to begin a load.
- load_base  input  8  — first word index to write. Sampled with `load_start`.
- load_len  input  8  — number of words to write; 0 means 256. Sampled with `load_start`.
- in_data  input  8  — stream byte.
- in_valid  input  1  — `in_data` is valid.
- in_ready  output  1  — block can accept a byte.
- busy  output  1  — a load is in progress.
- cpu_stall  output  1  — same value as `busy`.
- done  output  1  — one-cycle pulse when a load completes.
- err  output  1  — checksum mismatch on the last load (see Configuration).

## Operation
- The store is initialised to all zeros at time 0. `rst_n` does not clear the store.
- FSM states: IDLE, LOAD, CHECK. CHECK exists only when checksum is compiled in.
- **IDLE**
  - `in_ready`=0, `busy`=0.
  - `load_start`=1 does the following, then moves to LOAD:
    - `wr_ptr` ← `load_base`
    - `words_left` ← `load_len` (9 bits; 0 becomes 256)
    - `byte_cnt` ← 0
    - `err` ← 0
    - checksum accumulator ← 0
- **LOAD**
  - `in_ready`=1. A byte is accepted on a clock edge where `in_valid` && `in_ready`.
  - Bytes arrive big-endian: the first byte goes to `[31:24]` and the fourth to `[7:0]`.
  - On the edge that accepts the fourth byte:
    - Write `store[wr_ptr]` ← the packed word.
    - `wr_ptr` increments modulo 256. It wraps from 0xFF to 0x00.
    - `words_left` decrements.
  - When `words_left` reaches 0, go to CHECK if compiled in; otherwise go to IDLE and pulse `done`.
- **CHECK**
  - `in_ready`=1. Accept one byte.
  - Set `err` = (byte != 8-bit sum of all data bytes, modulo 256).
  - Go to IDLE and pulse `done`.
- `load_start` while `busy` is ignored.
- Reset mid-load:
  - Go to IDLE with `busy`=0, `in_ready`=0, `done`=0, `err`=0.
  - Partially assembled bytes are discarded.
  - Words already written stay in the store.
- The CPU may read at any time. A read from a word written on the same edge returns the new value from the next cycle on.

## Timing
- Reset values: `in_ready`=0, `busy`=0, `cpu_stall`=0, `done`=0, `err`=0, FSM=IDLE.
- `load_start` sampled at edge N:
  - `busy` and `in_ready` are 1 from cycle N+1.
  - The earliest byte acceptance is at edge N+1.
- With no stalls, a load of L words takes 4L edges (4L+1 with checksum) from the first acceptance.
- Final acceptance at edge M:
  - `done`=1 during cycle M+1 only.
  - `busy`=0 and `in_ready`=0 from cycle M+1.
  - `err` is valid from M+1 and holds until the next `load_start` or reset.
- `in_valid` low simply stalls the transfer. No byte is lost and there is no timeout.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - The CHECK state exists.
  - One trailing checksum byte follows the data bytes.
  - `err` reports a mismatch.
- Not defined:
  - No trailing byte; LOAD goes straight to IDLE.
  - `err` is tied to 0.
  - No accumulator logic is built.

## Test plan
- **Reset and idle:** pulse `rst_n`=0 then 1 → all outputs 0; `INST` reads 0x00000000 at `Addr`=0x04.
- **Single-word load:** `load_start`, `load_base`=1, `load_len`=1; send bytes 0x10,0x22,0x00,0x02 back-to-back → `store[1]`=0x10220002, `INST`=0x10220002 at `Addr`=0x04; `done` pulses 1 cycle; `busy` was high 4 cycles (5 with checksum).
- **Wrap-around:** `load_base`=0xFF, `load_len`=2 with words 0x00210824, 0x00210825 → `store[0xFF]`=0x00210824, `store[0x00]`=0x00210825.
- **Stalls and ignored start:** drop `in_valid` for 3 cycles mid-word and assert `load_start` while `busy` → word still correct, `wr_ptr` unaffected, completes normally.
- **Reset mid-load:** assert `rst_n`=0 after 6 bytes of a 2-word load at base 8 → `store[8]` updated, `store[9]` unchanged, `busy`=0 next cycle.
- **Checksum (`LOADER_CHECKSUM_EN`):** word 0x01020304 with trailer 0x0A → `err`=0; with trailer 0x0B → `err`=1; `done` pulses in both cases.

Source files
------------

// File: rtl/inst_ram_loader.sv
// inst_ram_loader: writable instruction store for the single-cycle CPU.
//
// The read side behaves like the instruction ROM. INST is a combinational read
// of store[Addr[DEPTH_LOG2+1:2]].
//
// The write side is a byte-stream loader. A host issues a one-cycle load_start
// with load_base/load_len, then streams bytes over in_valid/in_ready. Every
// four bytes are packed big-endian (the first byte goes to [31:24]) into one
// word. That word is written at wr_ptr, and wr_ptr then advances modulo the
// store depth. busy/cpu_stall are high while a load is in progress. done
// pulses for one cycle when a load completes.
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   When it is defined, one trailing checksum byte follows the data bytes. It
//   must equal the 8-bit sum of all data bytes. err latches a mismatch and
//   holds until the next load_start or reset.
//   When it is undefined, err is tied to 0 and no accumulator is built.
//
// Ports:
//   clk, rst_n            clock; synchronous active-low reset (the store is not cleared)
//   Addr / INST           CPU instruction address / read data
//   load_start            one-cycle load command (ignored while busy)
//   load_base / load_len  first word index / word count (0 means a full store)
//   in_data, in_valid     stream byte and its valid
//   in_ready              loader can accept a byte
//   busy, cpu_stall       load in progress (identical)
//   done                  one-cycle completion pulse
//   err                   checksum mismatch on the last load
module inst_ram_loader #(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           Addr,
    output logic [31:0]           INST,
    input  logic                  load_start,
    input  logic [DEPTH_LOG2-1:0] load_base,
    input  logic [DEPTH_LOG2-1:0] load_len,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  busy,
    output logic                  cpu_stall,
    output logic                  done,
    output logic                  err
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, CHECK = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1} state_t;
`endif

    state_t state, state_next;

    // The word store powers up as all zeros. Reset intentionally leaves it alone.
    logic [31:0] store [DEPTH] = '{default: 32'h0};

    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2:0]   words_left;   // one extra bit so a full-store load fits
    logic [1:0]            byte_cnt;
    logic [23:0]           word_buf;     // first three bytes of the current word
    logic                  wr_en;
    logic                  finish;
    logic                  accept;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{Addr[31:DEPTH_LOG2+2], Addr[1:0]};

    assign INST      = store[Addr[DEPTH_LOG2+1:2]];
    assign busy      = (state != IDLE);
    assign cpu_stall = busy;
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        wr_en      = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: if (load_start) state_next = LOAD;
            LOAD: begin
                in_ready = 1'b1;
                // The fourth byte of a word completes it and triggers the write.
                if (in_valid && byte_cnt == 2'd3) begin
                    wr_en = 1'b1;
                    if (words_left == 1) begin
`ifdef LOADER_CHECKSUM_EN
                        state_next = CHECK;
`else
                        state_next = IDLE;
                        finish     = 1'b1;
`endif
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = IDLE;
                    finish     = 1'b1;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            words_left <= '0;
            byte_cnt   <= 2'd0;
            word_buf   <= 24'h0;
            done       <= 1'b0;
        end else begin
            done <= finish;
            if (state == IDLE && load_start) begin
                wr_ptr     <= load_base;
                words_left <= (load_len == '0) ? {1'b1, {DEPTH_LOG2{1'b0}}} : {1'b0, load_len};
                byte_cnt   <= 2'd0;
            end else if (state == LOAD && accept) begin
                byte_cnt <= byte_cnt + 2'd1;
                word_buf <= {word_buf[15:0], in_data};
                if (wr_en) begin
                    wr_ptr     <= wr_ptr + 1'b1;
                    words_left <= words_left - 1'b1;
                end
            end
        end
    end

    // Writes are gated by rst_n so that a completing word is dropped when reset is applied.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) store[wr_ptr] <= {word_buf, in_data};
    end

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            csum <= 8'h0;
            err  <= 1'b0;
        end else if (state == IDLE && load_start) begin
            csum <= 8'h0;
            err  <= 1'b0;
        end else if (state == LOAD && accept) begin
            csum <= csum + in_data;
        end else if (state == CHECK && accept) begin
            err <= (in_data != csum);
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_inst_ram_loader.sv
module tb_inst_ram_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] Addr = 32'h0;
    logic [31:0] INST;
    logic        load_start = 1'b0;
    logic [7:0]  load_base = 8'h0;
    logic [7:0]  load_len = 8'h0;
    logic [7:0]  in_data = 8'h0;
    logic        in_valid = 1'b0;
    logic        in_ready, busy, cpu_stall, done, err;

`ifdef LOADER_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    inst_ram_loader #(.DEPTH_LOG2(8)) dut (
        .clk(clk), .rst_n(rst_n), .Addr(Addr), .INST(INST),
        .load_start(load_start), .load_base(load_base), .load_len(load_len),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .busy(busy), .cpu_stall(cpu_stall), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int busy_cycles = 0;
    int done_cnt = 0;
    logic [31:0] mem [256];          // reference contents of the store
    logic [31:0] load_words[$];      // words for the next load (random if short)
    logic [7:0]  run_sum;
    logic [7:0]  trailer_delta = 8'h0;

    typedef struct {
        logic [7:0]  base;
        logic [7:0]  len;
        logic [31:0] w0, w1;
        logic [31:0] a0, e0, a1, e1;
    } vec_t;
    vec_t vecs [3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (busy) busy_cycles++;
        if (done) done_cnt++;
        check("stall_eq_busy", {31'h0, cpu_stall}, {31'h0, busy});
    end

    task automatic read_chk(input string name, input logic [7:0] idx, input logic [31:0] exp);
        logic [31:0] r;
        r = $urandom;
        @(negedge clk);
        Addr = {r[31:10], idx, r[1:0]};
        #1;
        check(name, INST, exp);
    endtask

    task automatic start_load(input logic [7:0] base, input logic [7:0] len);
        @(negedge clk);
        load_start = 1'b1; load_base = base; load_len = len;
        @(posedge clk);
        #1;
        load_start = 1'b0; load_base = $urandom; load_len = $urandom;
        run_sum = 8'h0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        repeat (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        @(negedge clk);
        in_data = b; in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("accept_timeout", {31'h0, in_ready}, 32'h1);
        @(posedge clk);
        run_sum = run_sum + b;
    endtask

    task automatic finish_load(input logic exp_err);
        int k;
        k = 0;
        @(negedge clk);
        in_valid = 1'b0;
        while (!done && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("done_seen", {31'h0, done}, 32'h1);
        check("done_latency", k, 0);
        check("busy_at_done", {31'h0, busy}, 32'h0);
        check("ready_at_done", {31'h0, in_ready}, 32'h0);
        check("err_at_done", {31'h0, err}, {31'h0, exp_err});
        @(negedge clk);
        check("done_one_cycle", {31'h0, done}, 32'h0);
        check("err_hold", {31'h0, err}, {31'h0, exp_err});
    endtask

    // Full load: base/len, words from load_words (random when exhausted), model update.
    task automatic do_load(input logic [7:0] base, input logic [7:0] len, input int gap_max);
        int n;
        logic [31:0] w;
        logic exp_e;
        n = (len == 8'h0) ? 256 : int'(len);
        busy_cycles = 0; done_cnt = 0;
        start_load(base, len);
        for (int i = 0; i < n; i++) begin
            w = (i < load_words.size()) ? load_words[i] : $urandom;
            for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8], $urandom_range(gap_max, 0));
            mem[8'(int'(base) + i)] = w;
        end
        exp_e = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        send_byte(run_sum + trailer_delta, 0);
        exp_e = (trailer_delta != 8'h0);
`endif
        finish_load(exp_e);
        check("done_pulses", done_cnt, 1);
        if (gap_max == 0) check("busy_cycles", busy_cycles, 4 * n + CS);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b8, l8;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;

        vecs[0] = '{8'h01, 8'd1, 32'h10220002, 32'h0, 32'h004, 32'h10220002, 32'h008, 32'h0};
        vecs[1] = '{8'hFF, 8'd2, 32'h00210824, 32'h00210825, 32'h3FC, 32'h00210824, 32'h000, 32'h00210825};
        vecs[2] = '{8'h7F, 8'd2, 32'hDEADBEEF, 32'h000000FF, 32'h1FC, 32'hDEADBEEF, 32'h200, 32'h000000FF};

        // Reset and idle
        repeat (2) @(negedge clk);
        check("rst_ready", {31'h0, in_ready}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", {31'h0, busy}, 32'h0);
        check("idle_ready", {31'h0, in_ready}, 32'h0);
        Addr = 32'h04;
        #1;
        check("idle_inst", INST, 32'h0);

        // Table-driven loads
        for (int v = 0; v < 3; v++) begin
            load_words = {vecs[v].w0, vecs[v].w1};
            do_load(vecs[v].base, vecs[v].len, 0);
            @(negedge clk);
            Addr = vecs[v].a0; #1; check("vec_a0", INST, vecs[v].e0);
            @(negedge clk);
            Addr = vecs[v].a1; #1; check("vec_a1", INST, vecs[v].e1);
        end

        // Stall mid-word plus a load_start while busy
        busy_cycles = 0; done_cnt = 0;
        start_load(8'h20, 8'd2);
        send_byte(8'hCA, 0); send_byte(8'hFE, 0);
        @(negedge clk);
        in_valid = 1'b0; load_start = 1'b1; load_base = 8'h50; load_len = 8'd1;
        @(negedge clk);
        load_start = 1'b0;
        @(negedge clk);
        send_byte(8'hF0, 0); send_byte(8'h0D, 0);
        send_byte(8'h12, 0); send_byte(8'h34, 0); send_byte(8'h56, 0); send_byte(8'h78, 0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(run_sum, 0);
`endif
        finish_load(1'b0);
        check("stall_done_pulses", done_cnt, 1);
        mem[8'h20] = 32'hCAFEF00D; mem[8'h21] = 32'h12345678;
        read_chk("stall_w0", 8'h20, 32'hCAFEF00D);
        read_chk("stall_w1", 8'h21, 32'h12345678);
        read_chk("stall_ign", 8'h50, mem[8'h50]);

        // Reset mid-load after six bytes of a two-word load at base 8
        start_load(8'h08, 8'd2);
        send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
        send_byte(8'h44, 0); send_byte(8'h55, 0); send_byte(8'h66, 0);
        @(negedge clk);
        in_valid = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", {31'h0, busy}, 32'h0);
        check("mid_rst_ready", {31'h0, in_ready}, 32'h0);
        check("mid_rst_done", {31'h0, done}, 32'h0);
        check("mid_rst_err", {31'h0, err}, 32'h0);
        rst_n = 1'b1;
        mem[8'h08] = 32'h11223344;
        read_chk("mid_rst_w8", 8'h08, 32'h11223344);
        read_chk("mid_rst_w9", 8'h09, mem[8'h09]);
        load_words = {32'hAABBCCDD};
        do_load(8'h09, 8'd1, 0);
        read_chk("post_rst_w9", 8'h09, 32'hAABBCCDD);

`ifdef LOADER_CHECKSUM_EN
        load_words = {32'h01020304};
        trailer_delta = 8'h00;
        do_load(8'h30, 8'd1, 0);
        trailer_delta = 8'h01;
        do_load(8'h31, 8'd1, 0);
        @(negedge clk);
        check("err_sticky", {31'h0, err}, 32'h1);
        trailer_delta = 8'h00;
`endif

        // Randomised loads with stalls, checked against the model
        load_words = {};
        for (int t = 0; t < 15; t++) begin
            b8 = $urandom;
            l8 = 8'($urandom_range(6, 1));
`ifdef LOADER_CHECKSUM_EN
            trailer_delta = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
`endif
            do_load(b8, l8, 2);
            for (int i = -1; i <= int'(l8); i++) read_chk("rand_word", 8'(int'(b8) + i), mem[8'(int'(b8) + i)]);
        end
        trailer_delta = 8'h00;

        // Length 0 means a full 256-word load
        do_load(8'h80, 8'h00, 0);
        for (int i = 0; i < 256; i++) read_chk("sweep", 8'(i), mem[i]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
